// File: rtl/alu_cmd_pkg.sv
// Shared opcodes, FSM states and response record for the ALU command controller.
// ALU_CMD_ADC_EN makes opcode 101 a legal add-with-carry; otherwise it is illegal.
package alu_cmd_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_ILL = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, ADC2, RESP} state_t;

  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             carry;
    logic             err;
  } rsp_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_ILL:  return 1'b0;
`ifdef ALU_CMD_ADC_EN
      OP_ADC:  return 1'b1;
`else
      OP_ADC:  return 1'b0;
`endif
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Command and response valid/ready channels between a command source and alu_cmd_ctrl.
interface alu_cmd_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int RW     = 2
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [RW-1:0]     cmd_rd;
  logic [RW-1:0]     cmd_rs1;
  logic [RW-1:0]     cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_cmd_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one synchronous write port.
module alu_cmd_regfile #(
  parameter  int DATA_W = 4,
  parameter  int NREG   = 4,
  localparam int RW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [RW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the 4-bit ALU: register file, carry flag, handshakes.
// Define ALU_CMD_ADC_EN to build the two-pass ADC (EXEC -> ADC2) sequence.
module alu_cmd_ctrl
  import alu_cmd_pkg::*;
#(
  parameter  int DATA_W = ALU_W,
  parameter  int NREG   = 4,
  localparam int RW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_ctrl_if.slave     bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry
);
  state_t            state;
  rsp_t              rsp;
  logic              rsp_valid;
  logic              cmd_ready;
  logic              flag;
  logic              adc_q;
  logic [RW-1:0]     rd_q;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              we;
  logic [RW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic              accept;

  assign accept = (state == IDLE) && cmd_ready && bus.cmd_valid;

  alu_cmd_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk(clk), .rst(rst),
    .raddr1(bus.cmd_rs1), .rdata1(rdata1),
    .raddr2(bus.cmd_rs2), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always_comb begin
    we    = 1'b0;
    waddr = rd_q;
    wdata = alu_result;
    case (state)
      IDLE: if (accept && bus.cmd_op == OP_LDI) begin
        we    = 1'b1;
        waddr = bus.cmd_rd;
        wdata = bus.cmd_imm;
      end
      EXEC: we = !adc_q;
`ifdef ALU_CMD_ADC_EN
      ADC2: we = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef ALU_CMD_ADC_EN
  logic exec_carry;
  always_ff @(posedge clk) begin
    if (rst)                exec_carry <= 1'b0;
    else if (state == EXEC) exec_carry <= alu_carry;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flag      <= 1'b0;
      adc_q     <= 1'b0;
      rd_q      <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= OP_ADD;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= !accept;
          if (accept) begin
            rd_q  <= bus.cmd_rd;
            adc_q <= (bus.cmd_op == OP_ADC) && op_legal(bus.cmd_op);
            if (bus.cmd_op == OP_LDI) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp       <= '{data: bus.cmd_imm, carry: flag, err: 1'b0};
            end else if (!op_legal(bus.cmd_op)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp       <= '{data: '0, carry: flag, err: 1'b1};
            end else begin
              state   <= EXEC;
              alu_a   <= rdata1;
              alu_b   <= rdata2;
              // ADC's first pass is a plain rs1+rs2 add; the flag is folded in by ADC2.
              alu_sel <= (bus.cmd_op == OP_ADC) ? OP_ADD : bus.cmd_op;
            end
          end
        end
        EXEC: begin
          if (adc_q) begin
            state   <= ADC2;
            alu_a   <= alu_result;
            alu_b   <= {{(DATA_W-1){1'b0}}, flag};
            alu_sel <= OP_ADD;
          end else begin
            state     <= RESP;
            flag      <= alu_carry;
            rsp_valid <= 1'b1;
            rsp       <= '{data: alu_result, carry: alu_carry, err: 1'b0};
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_ADD;
          end
        end
`ifdef ALU_CMD_ADC_EN
        ADC2: begin
          state     <= RESP;
          flag      <= exec_carry | alu_carry;
          rsp_valid <= 1'b1;
          rsp       <= '{data: alu_result, carry: exec_carry | alu_carry, err: 1'b0};
          alu_a     <= '0;
          alu_b     <= '0;
          alu_sel   <= OP_ADD;
        end
`endif
        RESP: begin
          if (bus.rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp       <= '0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp.data;
  assign bus.rsp_carry = rsp.carry;
  assign bus.rsp_err   = rsp.err;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: directed table, hand sequences, randomized vs model.
module tb_alu_cmd_ctrl;
  localparam int DATA_W = 4;
  localparam int NREG   = 4;
  localparam int RW     = 2;
`ifdef ALU_CMD_ADC_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]        alu_sel;
  logic              alu_carry;
  logic [DATA_W:0]   alu_wide;

  alu_cmd_ctrl_if #(.DATA_W(DATA_W), .RW(RW)) bus ();

  alu_cmd_ctrl #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // Combinational ALU that sits beside the controller at the top level.
  always_comb begin
    alu_wide = '0;
    case (alu_sel)
      3'b000:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_wide = {1'b0, alu_a & alu_b};
      3'b011:  alu_wide = {1'b0, alu_a | alu_b};
      3'b100:  alu_wide = {1'b0, ~alu_a};
      default: alu_wide = '0;
    endcase
  end
  assign alu_result = alu_wide[DATA_W-1:0];
  assign alu_carry  = alu_wide[DATA_W];

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int mreg [NREG];
  int mflag;

  typedef struct {
    int op, rd, rs1, rs2, imm;
    int data, carry, err, lat;
  } vec_t;

  localparam int NDIR = 14;
  vec_t tbl [NDIR];

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input int idx);
    n_vec++;
    n_bad++;
    $display("FAIL %s[%0d]: timed out", name, idx);
  endtask

  // Architectural model: values are plain integers, carry is "sum exceeded 15" / "went negative".
  task automatic model(input int op, input int rd, input int rs1, input int rs2, input int imm,
                       output int data, output int carry, output int err, output int lat);
    int a, b, t;
    a = mreg[rs1];
    b = mreg[rs2];
    data = 0; carry = mflag; err = 0; lat = 2;
    case (op)
      0: begin t = a + b; data = t % 16; carry = (t > 15) ? 1 : 0; end
      1: begin t = a - b; data = (t + 16) % 16; carry = (t < 0) ? 1 : 0; end
      2: begin data = a & b; carry = 0; end
      3: begin data = a | b; carry = 0; end
      4: begin data = 15 - a; carry = 0; end
      5: if (ADC_EN) begin
           t = a + b + mflag; data = t % 16; carry = (t > 15) ? 1 : 0; lat = 3;
         end else begin
           err = 1; lat = 1;
         end
      6: begin err = 1; lat = 1; end
      default: begin data = imm; lat = 1; end
    endcase
    if (err == 0) begin
      mreg[rd] = data;
      mflag    = carry;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mreg[i] = 0;
    mflag = 0;
  endtask

  task automatic run_cmd(input int op, input int rd, input int rs1, input int rs2, input int imm,
                         input int stall, input int idx,
                         output int data, output int carry, output int err, output int lat);
    int n;
    bit stable;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.cmd_ready !== 1'b1) fail_now("cmd_ready_wait", idx);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op[2:0];
    bus.cmd_rd    = rd[RW-1:0];
    bus.cmd_rs1   = rs1[RW-1:0];
    bus.cmd_rs2   = rs2[RW-1:0];
    bus.cmd_imm   = imm[DATA_W-1:0];
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
    if (bus.rsp_valid !== 1'b1) begin
      fail_now("rsp_valid_wait", idx);
      data = -1; carry = -1; err = -1;
      return;
    end
    data  = int'(bus.rsp_data);
    carry = int'(bus.rsp_carry);
    err   = int'(bus.rsp_err);
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_data) != data || int'(bus.rsp_carry) != carry ||
          int'(bus.rsp_err) != err || bus.cmd_ready !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) check("hold_stable", idx, int'(stable), 1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("retired", idx, int'(bus.rsp_valid), 0);
    check("ready_after_retire", idx, int'(bus.cmd_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog[0]: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d, c, e, l, md, mc, me, ml, n;
    // op, rd, rs1, rs2, imm, data, carry, err, lat
    tbl[0]  = '{7, 0, 0, 0, 9,   9, 0, 0, 1};
    tbl[1]  = '{7, 1, 0, 0, 8,   8, 0, 0, 1};
    tbl[2]  = '{0, 2, 0, 1, 0,   1, 1, 0, 2};
    tbl[3]  = '{1, 3, 1, 0, 0,  15, 1, 0, 2};
    tbl[4]  = '{2, 3, 0, 1, 0,   8, 0, 0, 2};
    tbl[5]  = '{4, 0, 0, 2, 0,   6, 0, 0, 2};
    tbl[6]  = '{6, 2, 0, 1, 0,   0, 0, 1, 1};
    tbl[7]  = '{3, 1, 0, 3, 0,  14, 0, 0, 2};
    tbl[8]  = '{0, 1, 1, 1, 0,  12, 1, 0, 2};
    tbl[9]  = '{6, 0, 1, 2, 0,   0, 1, 1, 1};
    tbl[10] = '{7, 2, 0, 0, 3,   3, 1, 0, 1};
    tbl[11] = '{1, 2, 2, 1, 0,   7, 1, 0, 2};
    if (ADC_EN) tbl[12] = '{5, 3, 2, 3, 0,   0, 1, 0, 3};
    else        tbl[12] = '{5, 3, 2, 3, 0,   0, 1, 1, 1};
    tbl[13] = '{1, 0, 0, 0, 0,   0, 0, 0, 2};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0;
    bus.cmd_rs2 = '0; bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 0, int'(bus.cmd_ready), 0);
    check("rst_rsp_valid", 0, int'(bus.rsp_valid), 0);
    check("rst_rsp_data", 0, int'(bus.rsp_data), 0);
    check("rst_rsp_carry", 0, int'(bus.rsp_carry), 0);
    check("rst_rsp_err", 0, int'(bus.rsp_err), 0);
    check("rst_alu", 0, int'({alu_a, alu_b, alu_sel}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 0, int'(bus.cmd_ready), 1);

    for (int i = 0; i < NDIR; i++) begin
      model(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, md, mc, me, ml);
      run_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 0, i, d, c, e, l);
      check("dir_data", i, d, tbl[i].data);
      check("dir_carry", i, c, tbl[i].carry);
      check("dir_err", i, e, tbl[i].err);
      check("dir_lat", i, l, tbl[i].lat);
    end
    check("idle_alu", 0, int'({alu_a, alu_b, alu_sel}), 0);

    // Back-pressure: response held for five cycles with rsp_ready low.
    model(7, 1, 0, 0, 5, md, mc, me, ml);
    run_cmd(7, 1, 0, 0, 5, 5, 100, d, c, e, l);
    check("stall_data", 100, d, 5);
    check("stall_lat", 100, l, 1);

    // Set the flag, then reset while an ADD sits in EXEC.
    model(7, 0, 0, 0, 15, md, mc, me, ml);
    run_cmd(7, 0, 0, 0, 15, 0, 101, d, c, e, l);
    model(0, 1, 0, 0, 0, md, mc, me, ml);
    run_cmd(0, 1, 0, 0, 0, 0, 102, d, c, e, l);
    check("pre_rst_carry", 102, c, 1);
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'b000; bus.cmd_rd = 2'd2;
    bus.cmd_rs1 = 2'd0; bus.cmd_rs2 = 2'd1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("exec_alu_a", 103, int'(alu_a), 15);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_rsp_valid", 103, int'(bus.rsp_valid), 0);
    check("abort_cmd_ready", 103, int'(bus.cmd_ready), 0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("ready_after_abort", 103, int'(bus.cmd_ready), 1);
    n = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.rsp_valid !== 1'b0) n++; end
    check("no_rsp_after_abort", 103, n, 0);
    model(6, 0, 0, 0, 0, md, mc, me, ml);
    run_cmd(6, 0, 0, 0, 0, 0, 104, d, c, e, l);
    check("flag_cleared", 104, c, 0);
    check("ill_err", 104, e, 1);
    model(0, 2, 0, 1, 0, md, mc, me, ml);
    run_cmd(0, 2, 0, 1, 0, 0, 105, d, c, e, l);
    check("regs_cleared", 105, d, 0);
    model(4, 3, 0, 0, 0, md, mc, me, ml);
    run_cmd(4, 3, 0, 0, 0, 0, 106, d, c, e, l);
    check("not_zero", 106, d, 15);

    for (int i = 0; i < 80; i++) begin
      int op, rd, rs1, rs2, imm, st;
      op  = int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, NREG - 1));
      rs1 = int'($urandom_range(0, NREG - 1));
      rs2 = int'($urandom_range(0, NREG - 1));
      imm = int'($urandom_range(0, 15));
      st  = int'($urandom_range(0, 2));
      model(op, rd, rs1, rs2, imm, md, mc, me, ml);
      run_cmd(op, rd, rs1, rs2, imm, st, 200 + i, d, c, e, l);
      check("rnd_data", 200 + i, d, md);
      check("rnd_carry", 200 + i, c, mc);
      check("rnd_err", 200 + i, e, me);
      check("rnd_lat", 200 + i, l, ml);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
